// File: rtl/yutorina_ex_stage.sv
// yutorina_ex_stage: execute stage of the yutorina pipeline.
// Takes the decoded id_* bundle, runs the ALU and registers the ex_* bundle
// for MEM. ex_fwd_addr/ex_fwd_out feed the result back to decode.
// Optional feature macro: YUTORINA_MULDIV_EN enables the iterative MUL/DIVU unit
// (33-cycle latency, busy_ stall request). Without it MUL/DIVU are undefined ops.
// md_state exposes the mul/div FSM state (always IDLE when the unit is absent).
// Handshake: id_en_ (active-low) qualifies the id_* bundle for one cycle; it is
// taken on the rising edge when stall and flush are low and busy_ is high.
// ex_en_ (active-low) marks a fresh result; it stays asserted while stall holds.
module yutorina_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_en_,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_lhs,
    input  logic [31:0] id_alu_rhs,
    input  logic [4:0]  id_w_addr,
    input  logic [31:0] id_w_data,
    input  logic        id_gpr_we_,
    input  logic [2:0]  id_exp_code,
    input  logic [1:0]  id_mem_op,
    input  logic [1:0]  id_ctrl_op,
    output logic        ex_en_,
    output logic [31:0] ex_alu_out,
    output logic [4:0]  ex_w_addr,
    output logic [31:0] ex_w_data,
    output logic        ex_gpr_we_,
    output logic [1:0]  ex_mem_op,
    output logic [1:0]  ex_ctrl_op,
    output logic [2:0]  ex_exp_code,
    output logic [4:0]  ex_fwd_addr,
    output logic [31:0] ex_fwd_out,
    output logic        busy_,
    output logic [1:0]  md_state
);

    localparam logic       ENABLE_  = 1'b0;
    localparam logic       DISABLE_ = 1'b1;
    localparam logic [4:0] GPR_ZERO = 5'd0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SAR  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    localparam logic [1:0] MEM_NONE       = 2'd0;
    localparam logic [1:0] CTRL_NONE      = 2'd0;
    localparam logic [2:0] EXP_NONE       = 3'd0;
    localparam logic [2:0] EXP_UNDEF_INSN = 3'd2;

    logic [31:0] alu_out;
    logic [2:0]  alu_exp;
    logic        alu_we_;

`ifdef YUTORINA_MULDIV_EN
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t   state_q, state_d;
    logic        is_md;
    logic        md_start;
    logic [4:0]  md_cnt;
    logic [31:0] md_a;      // multiplicand (MUL) or dividend/quotient (DIVU)
    logic [31:0] md_b;      // multiplier (MUL) or divisor (DIVU)
    logic [31:0] md_acc;    // product (MUL) or partial remainder (DIVU)
    logic        md_div;
    logic [4:0]  md_w_addr;
    logic        md_we_;
    logic [2:0]  md_exp;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem_next;
    logic [31:0] md_result;
`endif

    // ALU: single-cycle result, exception and write-enable for the id_* bundle
    always_comb begin
        alu_out = '0;
        alu_exp = id_exp_code;
        alu_we_ = id_gpr_we_;
`ifdef YUTORINA_MULDIV_EN
        is_md   = 1'b0;
`endif
        case (id_alu_op)
            // NOP passes lhs through so it can serve as a move
            OP_NOP:  alu_out = id_alu_lhs;
            OP_ADD:  alu_out = id_alu_lhs + id_alu_rhs;
            OP_SUB:  alu_out = id_alu_lhs - id_alu_rhs;
            OP_AND:  alu_out = id_alu_lhs & id_alu_rhs;
            OP_OR:   alu_out = id_alu_lhs | id_alu_rhs;
            OP_XOR:  alu_out = id_alu_lhs ^ id_alu_rhs;
            OP_SHL:  alu_out = id_alu_lhs << id_alu_rhs[4:0];
            OP_SHR:  alu_out = id_alu_lhs >> id_alu_rhs[4:0];
            OP_SAR:  alu_out = $unsigned($signed(id_alu_lhs) >>> id_alu_rhs[4:0]);
            OP_SLT:  alu_out = {31'b0, ($signed(id_alu_lhs) < $signed(id_alu_rhs))};
            OP_SLTU: alu_out = {31'b0, (id_alu_lhs < id_alu_rhs)};
            OP_MUL, OP_DIVU: begin
`ifdef YUTORINA_MULDIV_EN
                is_md   = 1'b1;
`else
                alu_exp = EXP_UNDEF_INSN;
                alu_we_ = DISABLE_;
`endif
            end
            default: alu_exp = EXP_UNDEF_INSN;
        endcase
    end

`ifdef YUTORINA_MULDIV_EN
    assign md_start     = (state_q == MD_IDLE) && (id_en_ == ENABLE_) && is_md && !stall && !flush;
    assign div_shift    = {md_acc, md_a[31]};
    assign div_ge       = (div_shift >= {1'b0, md_b});
    // true remainder is below the divisor, so the low 32 bits are exact
    assign div_rem_next = div_shift[31:0] - md_b;
    assign md_result    = md_div ? md_a : md_acc;
    assign md_state     = state_q;

    // Mul/div FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MD_IDLE;
        else      state_q <= state_d;
    end

    // Mul/div FSM next state: flush aborts from any state, DONE waits out stall
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: if (md_start) state_d = MD_BUSY;
                MD_BUSY: if (md_cnt == 5'd0) state_d = MD_DONE;
                MD_DONE: if (!stall) state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // Mul/div datapath: operand latch, one shift-add or restoring step per BUSY cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt    <= '0;
            md_a      <= '0;
            md_b      <= '0;
            md_acc    <= '0;
            md_div    <= 1'b0;
            md_w_addr <= GPR_ZERO;
            md_we_    <= DISABLE_;
            md_exp    <= EXP_NONE;
            busy_     <= DISABLE_;
        end else begin
            if (md_start) begin
                md_cnt    <= 5'd31;
                md_a      <= id_alu_lhs;
                md_b      <= id_alu_rhs;
                md_acc    <= '0;
                md_div    <= (id_alu_op == OP_DIVU);
                md_w_addr <= id_w_addr;
                md_we_    <= id_gpr_we_;
                md_exp    <= id_exp_code;
                busy_     <= ENABLE_;
            end else if (state_q == MD_BUSY) begin
                md_cnt <= md_cnt - 5'd1;
                if (md_div) begin
                    md_acc <= div_ge ? div_rem_next : div_shift[31:0];
                    md_a   <= {md_a[30:0], div_ge};
                end else begin
                    if (md_b[0]) md_acc <= md_acc + md_a;
                    md_a <= md_a << 1;
                    md_b <= md_b >> 1;
                end
            end
            if (flush || ((state_q == MD_DONE) && !stall)) busy_ <= DISABLE_;
        end
    end
`else
    assign busy_    = DISABLE_;
    assign md_state = 2'd0;
`endif

    // ex_* pipeline register: flush > stall > mul/div completion > new instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_en_      <= DISABLE_;
            ex_alu_out  <= '0;
            ex_w_addr   <= GPR_ZERO;
            ex_w_data   <= '0;
            ex_gpr_we_  <= DISABLE_;
            ex_mem_op   <= MEM_NONE;
            ex_ctrl_op  <= CTRL_NONE;
            ex_exp_code <= EXP_NONE;
        end else if (flush) begin
            ex_en_     <= DISABLE_;
            ex_gpr_we_ <= DISABLE_;
            ex_mem_op  <= MEM_NONE;
        end else if (!stall) begin
`ifdef YUTORINA_MULDIV_EN
            if (state_q == MD_DONE) begin
                // mul/div results carry no store data and no memory/control op
                ex_en_      <= ENABLE_;
                ex_alu_out  <= md_result;
                ex_w_addr   <= md_w_addr;
                ex_w_data   <= '0;
                ex_gpr_we_  <= md_we_;
                ex_mem_op   <= MEM_NONE;
                ex_ctrl_op  <= CTRL_NONE;
                ex_exp_code <= md_exp;
            end else if ((state_q == MD_BUSY) || md_start) begin
                ex_en_ <= DISABLE_;
            end else
`endif
            if (id_en_ == ENABLE_) begin
                ex_en_      <= ENABLE_;
                ex_alu_out  <= alu_out;
                ex_w_addr   <= id_w_addr;
                ex_w_data   <= id_w_data;
                ex_gpr_we_  <= alu_we_;
                ex_mem_op   <= id_mem_op;
                ex_ctrl_op  <= id_ctrl_op;
                ex_exp_code <= alu_exp;
            end else begin
                ex_en_ <= DISABLE_;
            end
        end
    end

    // Forwarding: only valid, GPR-writing, non-memory results go back to decode
    always_comb begin
        ex_fwd_addr = GPR_ZERO;
        ex_fwd_out  = '0;
        if ((ex_en_ == ENABLE_) && (ex_gpr_we_ == ENABLE_) && (ex_mem_op == MEM_NONE)) begin
            ex_fwd_addr = ex_w_addr;
        end
        if (ex_fwd_addr != GPR_ZERO) ex_fwd_out = ex_alu_out;
    end

endmodule

// File: tb/tb_yutorina_ex_stage.sv
// tb_yutorina_ex_stage: scoreboard bench for yutorina_ex_stage.
// Directed cases plus randomized traffic; expected results come from a plain
// arithmetic reference model and are queued when an instruction is accepted.
module tb_yutorina_ex_stage;

  localparam int W = 77;  // {alu 32, w_addr 5, w_data 32, we_ 1, mem 2, ctrl 2, exp 3}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_en_ = 1'b1;
  logic [3:0]  id_alu_op = '0;
  logic [31:0] id_alu_lhs = '0;
  logic [31:0] id_alu_rhs = '0;
  logic [4:0]  id_w_addr = '0;
  logic [31:0] id_w_data = '0;
  logic        id_gpr_we_ = 1'b1;
  logic [2:0]  id_exp_code = '0;
  logic [1:0]  id_mem_op = '0;
  logic [1:0]  id_ctrl_op = '0;
  logic        ex_en_;
  logic [31:0] ex_alu_out;
  logic [4:0]  ex_w_addr;
  logic [31:0] ex_w_data;
  logic        ex_gpr_we_;
  logic [1:0]  ex_mem_op;
  logic [1:0]  ex_ctrl_op;
  logic [2:0]  ex_exp_code;
  logic [4:0]  ex_fwd_addr;
  logic [31:0] ex_fwd_out;
  logic        busy_;
  logic [1:0]  md_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_pushed = '0;
  logic         last_accept = 1'b0;
  int checks = 0;
  int errors = 0;

  yutorina_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_en_(id_en_), .id_alu_op(id_alu_op), .id_alu_lhs(id_alu_lhs),
    .id_alu_rhs(id_alu_rhs), .id_w_addr(id_w_addr), .id_w_data(id_w_data),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code), .id_mem_op(id_mem_op),
    .id_ctrl_op(id_ctrl_op), .ex_en_(ex_en_), .ex_alu_out(ex_alu_out),
    .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data), .ex_gpr_we_(ex_gpr_we_),
    .ex_mem_op(ex_mem_op), .ex_ctrl_op(ex_ctrl_op), .ex_exp_code(ex_exp_code),
    .ex_fwd_addr(ex_fwd_addr), .ex_fwd_out(ex_fwd_out), .busy_(busy_),
    .md_state(md_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic bit is_md_op(input logic [3:0] op);
`ifdef YUTORINA_MULDIV_EN
    return (op == 4'd11) || (op == 4'd12);
`else
    return (op == 4'hf) && (op != 4'hf);
`endif
  endfunction

  // reference model: what the MEM stage should receive for one instruction
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [31:0] l,
      input logic [31:0] r, input logic [4:0] wa, input logic [31:0] wd, input logic we,
      input logic [1:0] mem, input logic [1:0] ctrl, input logic [2:0] ex);
    logic [31:0] res;
    logic [63:0] prod;
    logic [31:0] wdo;
    logic [2:0]  e;
    logic        w;
    logic [1:0]  m;
    logic [1:0]  c;
    res = '0; e = ex; w = we; wdo = wd; m = mem; c = ctrl;
    case (op)
      4'd0:  res = l;
      4'd1:  res = l + r;
      4'd2:  res = l - r;
      4'd3:  res = l & r;
      4'd4:  res = l | r;
      4'd5:  res = l ^ r;
      4'd6:  res = l << r[4:0];
      4'd7:  res = l >> r[4:0];
      4'd8:  res = $unsigned($signed(l) >>> r[4:0]);
      4'd9:  res = ($signed(l) < $signed(r)) ? 32'd1 : 32'd0;
      4'd10: res = (l < r) ? 32'd1 : 32'd0;
      4'd11, 4'd12: begin
`ifdef YUTORINA_MULDIV_EN
        prod = {32'd0, l} * {32'd0, r};
        if (op == 4'd11) res = prod[31:0];
        else res = (r == 32'd0) ? 32'hFFFF_FFFF : l / r;
        wdo = '0; m = 2'd0; c = 2'd0;
`else
        prod = '0;
        res = '0; e = 3'd2; w = 1'b1;
`endif
      end
      default: begin res = '0; e = 3'd2; end
    endcase
    return {res, wa, wdo, w, m, c, e};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // scoreboard monitor: a fresh result appears on an edge with stall low and ex_en_ asserted
  always @(posedge clk) begin
    logic st;
    logic [W-1:0] e;
    logic [4:0]  fa;
    logic [31:0] fo;
    st = stall;
    #1;
    if (!st && rst && ex_en_ == 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {ex_alu_out, ex_w_addr, ex_w_data, ex_gpr_we_,
              ex_mem_op, ex_ctrl_op, ex_exp_code}, '0);
      end else begin
        e = exp_q.pop_front();
        check("ex_bundle", {ex_alu_out, ex_w_addr, ex_w_data, ex_gpr_we_, ex_mem_op,
              ex_ctrl_op, ex_exp_code}, e);
        fa = (e[7] == 1'b0 && e[6:5] == 2'd0) ? e[44:40] : 5'd0;
        fo = (fa != 5'd0) ? e[76:45] : 32'd0;
        check("forward", {40'd0, ex_fwd_addr, ex_fwd_out}, {40'd0, fa, fo});
      end
    end
  end

  // driver: present one cycle of id_* traffic (called at a negedge)
  task automatic cycle(input logic en, input logic [3:0] op, input logic [31:0] l,
      input logic [31:0] r, input logic [4:0] wa, input logic [31:0] wd, input logic we,
      input logic [1:0] mem, input logic [1:0] ctrl, input logic [2:0] ex,
      input logic st, input logic fl);
    id_en_ = en; id_alu_op = op; id_alu_lhs = l; id_alu_rhs = r; id_w_addr = wa;
    id_w_data = wd; id_gpr_we_ = we; id_mem_op = mem; id_ctrl_op = ctrl;
    id_exp_code = ex; stall = st; flush = fl;
    last_accept = (en == 1'b0) && !st && !fl;
    if (last_accept) begin
      last_pushed = model(op, l, r, wa, wd, we, mem, ctrl, ex);
      exp_q.push_back(last_pushed);
    end
    @(negedge clk);
    id_en_ = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  // upstream honours busy_: idle until the mul/div unit releases it
  task automatic wait_idle(input bit rnd_stall, output int n);
    n = 0;
    while (busy_ == 1'b0 && n < 300) begin
      stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      n++;
    end
    stall = 1'b0;
    if (n >= 300) begin
      errors++; checks++;
      $display("FAIL busy_timeout: got busy_ low for %0d cycles expected release", n);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_en"}, {76'd0, ex_en_}, {76'd0, 1'b1});
    check({tag, "_bundle"}, {ex_alu_out, ex_w_addr, ex_w_data, ex_gpr_we_, ex_mem_op,
          ex_ctrl_op, ex_exp_code}, {32'd0, 5'd0, 32'd0, 1'b1, 2'd0, 2'd0, 3'd0});
    check({tag, "_fwd"}, {40'd0, ex_fwd_addr, ex_fwd_out}, '0);
    check({tag, "_busy"}, {76'd0, busy_}, {76'd0, 1'b1});
    check({tag, "_state"}, {75'd0, md_state}, '0);
  endtask

  initial begin
    logic [W-1:0] held;
    int n;
    logic [3:0] op;
    logic [31:0] l, r;

    // reset
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);

    // directed: overflow wrap with forwarding, signed/unsigned compare, load
    cycle(1'b0, 4'd1, 32'h7FFF_FFFF, 32'd1, 5'd3, 32'h1234, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    check("add_fwd_addr", {72'd0, ex_fwd_addr}, {72'd0, 5'd3});
    check("add_fwd_out", {45'd0, ex_fwd_out}, {45'd0, 32'h8000_0000});
    cycle(1'b0, 4'd9, 32'hFFFF_FFFF, 32'd0, 5'd4, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd10, 32'hFFFF_FFFF, 32'd0, 5'd4, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd1, 32'h100, 32'h20, 5'd5, 32'hCAFE, 1'b0, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0);
    check("load_no_fwd", {40'd0, ex_fwd_addr, ex_fwd_out}, '0);

    // directed: ADD held off by three stalled cycles, then accepted
    held = last_pushed;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'd1, 32'd40, 32'd2, 5'd6, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
      check("stall_hold", {ex_alu_out, ex_w_addr, ex_w_data, ex_gpr_we_, ex_mem_op,
            ex_ctrl_op, ex_exp_code}, held);
      check("stall_hold_en", {76'd0, ex_en_}, '0);
    end
    cycle(1'b0, 4'd1, 32'd40, 32'd2, 5'd6, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    // undefined opcode and flush of a valid result
    cycle(1'b0, 4'd14, 32'd1, 32'd2, 5'd7, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd1, 32'd1, 32'd2, 5'd8, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    check("flush_kills", {75'd0, ex_en_, ex_gpr_we_}, {75'd0, 2'b11});

`ifdef YUTORINA_MULDIV_EN
    // directed mul/div: latency, divide by zero, product overflow
    cycle(1'b0, 4'd12, 32'd100, 32'd7, 5'd9, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    wait_idle(1'b0, n);
    check("divu_busy_cycles", W'(n), W'(33));
    cycle(1'b0, 4'd12, 32'd12345, 32'd0, 5'd10, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    wait_idle(1'b0, n);
    cycle(1'b0, 4'd11, 32'h10000, 32'h10000, 5'd11, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    wait_idle(1'b0, n);
    // flush on the tenth BUSY cycle: no result may appear
    cycle(1'b0, 4'd11, 32'd3, 32'd5, 5'd12, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("md_flush_busy", {75'd0, busy_, ex_en_}, {75'd0, 2'b11});
    repeat (40) @(negedge clk);
    // reset in the middle of BUSY
    cycle(1'b0, 4'd12, 32'd77, 32'd3, 5'd13, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midbusy_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`else
    // without the unit MUL/DIVU are undefined, single-cycle, no write
    cycle(1'b0, 4'd11, 32'd5, 32'd6, 5'd9, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd12, 32'd100, 32'd7, 5'd10, 32'd0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    check("no_md_busy", {76'd0, busy_}, {76'd0, 1'b1});
`endif

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      op = 4'($urandom_range(0, 15));
      l = (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom());
      r = (($urandom_range(0, 7) == 0) ? 32'd0 : $urandom());
      cycle(($urandom_range(0, 3) == 0), op, l, r, 5'($urandom_range(0, 31)), $urandom(),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      if (last_accept && is_md_op(op)) wait_idle(1'b1, n);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
